// File: rtl/uart_pkg.sv
// Shared types and limits for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register in front of the transmit shifter.
// Handshake: a word transfers on a rising clk edge where i_valid && o_ready;
// o_ready is registered and equals "holding register empty", so it drops the
// cycle after an accept and rises the cycle after the FSM takes the word.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_take,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_full;
  logic         r_ready;

  // Accept and take are mutually exclusive: accept needs empty, take needs full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_valid && r_ready) begin
      r_data  <= i_data;
      r_full  <= 1'b1;
      r_ready <= 1'b0;
    end else if (i_take) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_data;
  assign o_full  = r_full;

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits (LSB or MSB
// first), optional even/odd parity, 1 or 2 stop bits. Bit boundaries happen
// only on baud_tick; a queued word follows the last stop bit with no gap.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      DATA_BITS = 8,
  parameter int      STOP_BITS = 1,
  parameter parity_e PARITY    = PAR_NONE,
  parameter bit      LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic [2:0]           dbg_state
);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end

  localparam int CW = $clog2(MAX_DATA_BITS);

  localparam logic [2:0] ST_IDLE   = uart_pkg::IDLE;
  localparam logic [2:0] ST_START  = uart_pkg::START;
  localparam logic [2:0] ST_DATA   = uart_pkg::DATA;
  localparam logic [2:0] ST_PARITY = uart_pkg::PARITY;
  localparam logic [2:0] ST_STOP   = uart_pkg::STOP;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] ST_BREAK  = uart_pkg::BREAK;
`endif

  logic [2:0]           r_state,    w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic [CW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_par,      w_par_nxt;
  logic                 r_tx,       w_tx_nxt;
  logic                 r_done,     w_done_nxt;
  logic                 r_busy;

  logic                 w_take;
  logic                 w_hold_full;
  logic [DATA_BITS-1:0] w_hold_data;
  logic                 w_next_bit;
  logic [DATA_BITS-1:0] w_shift_adv;
  logic                 w_load_par;

  uart_tx_hold #(.W(DATA_BITS)) u_hold (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (s_data),
    .i_valid (s_valid),
    .o_ready (s_ready),
    .i_take  (w_take),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full)
  );

  // Bit presented next and the shifter after it has been consumed.
  assign w_next_bit  = LSB_FIRST ? r_shift[0] : r_shift[DATA_BITS-1];
  assign w_shift_adv = LSB_FIRST ? {1'b0, r_shift[DATA_BITS-1:1]}
                                 : {r_shift[DATA_BITS-2:0], 1'b0};
  // Parity is fixed at load time so the data word never has to be kept.
  assign w_load_par  = (^w_hold_data) ^ (PARITY == PAR_ODD);

  // Frame sequencing; every state change and line change waits for baud_tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_take         = 1'b0;
    if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_BREAK;
          end else
`endif
          if (w_hold_full) begin
            w_take      = 1'b1;
            w_shift_nxt = w_hold_data;
            w_par_nxt   = w_load_par;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
          end
        end
        ST_START: begin
          w_tx_nxt      = w_next_bit;
          w_shift_nxt   = w_shift_adv;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              w_tx_nxt    = r_par;
              w_state_nxt = ST_PARITY;
            end else begin
              w_tx_nxt       = 1'b1;
              w_stop_cnt_nxt = 1'b0;
              w_state_nxt    = ST_STOP;
            end
          end else begin
            w_tx_nxt      = w_next_bit;
            w_shift_nxt   = w_shift_adv;
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = ST_STOP;
        end
        ST_STOP: begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_done_nxt = 1'b1;
            if (w_hold_full) begin
              w_take      = 1'b1;
              w_shift_nxt = w_hold_data;
              w_par_nxt   = w_load_par;
              w_tx_nxt    = 1'b0;
              w_state_nxt = ST_START;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (!tx_break) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
`endif
        default: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset drives the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign tx_serial = r_tx;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances with different framing share clk,
// rst and a 1-in-16 baud_tick. Define UART_TX_BREAK_EN to cover line break.
module tb_uart_tx_frame;

  localparam int NI = 4;

  // Instance configuration as seen by the reference model.
  int cfg_db  [NI] = '{8, 7, 7, 8};
  int cfg_sb  [NI] = '{1, 1, 1, 2};
  int cfg_par [NI] = '{0, 1, 2, 0};   // 0 none, 1 even, 2 odd
  int cfg_lsb [NI] = '{1, 1, 1, 0};

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [8:0] s_data    [NI];
  logic       s_valid   [NI];
  logic       s_ready   [NI];
  logic       tx_serial [NI];
  logic       tx_busy   [NI];
  logic       tx_done   [NI];
  logic [2:0] dbg_state [NI];
`ifdef UART_TX_BREAK_EN
  logic       tx_break  [NI];
`endif

  int n_pass   = 0;
  int n_total  = 0;
  int timeouts = 0;
  int tcnt;
  logic [31:0] exp_q[$];

  typedef struct {
    int          idx;
    logic [8:0]  word;
    int          nbits;
    logic [31:0] exp_bits;   // bit i = line level during baud period i
  } vec_t;
  vec_t vecs [4];

  // ---------------- DUTs ----------------
  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(uart_pkg::PAR_NONE), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data[0][7:0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .tx_serial(tx_serial[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break[0]),
`endif
    .dbg_state(dbg_state[0]));

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(1), .PARITY(uart_pkg::PAR_EVEN), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data[1][6:0]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .tx_serial(tx_serial[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break[1]),
`endif
    .dbg_state(dbg_state[1]));

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(1), .PARITY(uart_pkg::PAR_ODD), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data[2][6:0]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .tx_serial(tx_serial[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break[2]),
`endif
    .dbg_state(dbg_state[2]));

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(uart_pkg::PAR_NONE), .LSB_FIRST(1'b0)) dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_data(s_data[3][7:0]), .s_valid(s_valid[3]),
    .s_ready(s_ready[3]), .tx_serial(tx_serial[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break[3]),
`endif
    .dbg_state(dbg_state[3]));

  // ---------------- clock / reset / baud ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      baud_tick = (tcnt == 15);
      tcnt = (tcnt == 15) ? 0 : tcnt + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Expected frame from the framing rules: start, data in send order,
  // optional parity over the data bits, then the stop bits.
  function automatic void model_frame(input int idx, input logic [8:0] w,
                                      output int n, output logic [31:0] f);
    int ones;
    f = '0;
    ones = 0;
    f[0] = 1'b0;
    n = 1;
    for (int i = 0; i < cfg_db[idx]; i++) begin
      int b;
      b = (cfg_lsb[idx] != 0) ? i : cfg_db[idx] - 1 - i;
      f[n] = w[b];
      ones += int'(w[b]);
      n++;
    end
    if (cfg_par[idx] != 0) begin
      f[n] = (cfg_par[idx] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < cfg_sb[idx]; s++) begin
      f[n] = 1'b1;
      n++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_tick();
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < 64) begin
      @(posedge clk);
      n++;
      if (baud_tick) ok = 1;
    end
    if (!ok) timeouts++;
  endtask

  task automatic send(input int idx, input logic [8:0] w);
    int n;
    @(negedge clk);
    s_data[idx]  = w;
    s_valid[idx] = 1'b1;
    n = 0;
    while (!s_ready[idx] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeouts++;
    @(posedge clk);
    #1;
    s_valid[idx] = 1'b0;
    s_data[idx]  = 9'($urandom);
  endtask

  // Observe nbits baud periods starting at the next tick. Records line level,
  // s_ready and tx_busy at the start of each period, which periods were
  // followed by a tx_done pulse, and counts periods that were not exactly 16
  // clocks of constant level or that saw tx_done mid-period.
  task automatic capture(input int idx, input int nbits,
                         output logic [31:0] bits, output logic [31:0] done_m,
                         output logic [31:0] rdy_m, output logic [31:0] busy_m,
                         output int bad);
    bits = '0; done_m = '0; rdy_m = '0; busy_m = '0; bad = 0;
    wait_tick();
    for (int b = 0; b < nbits; b++) begin
      int   len;
      logic v;
      #1;
      v         = tx_serial[idx];
      bits[b]   = v;
      rdy_m[b]  = s_ready[idx];
      busy_m[b] = tx_busy[idx];
      if (b > 0 && tx_done[idx]) done_m[b-1] = 1'b1;
      len = 1;
      while (1) begin
        @(posedge clk);
        if (baud_tick) break;
        #1;
        if (tx_serial[idx] !== v || tx_done[idx] !== 1'b0) bad++;
        len++;
        if (len > 40) begin
          bad++;
          break;
        end
      end
      if (len != 16) bad++;
    end
    #1;
    if (tx_done[idx]) done_m[nbits-1] = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] bits, done_m, rdy_m, busy_m, f0, f1, exp_f;
    int          bad, n0, n1;
    logic [8:0]  w;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      s_data[i]  = '0;
      s_valid[i] = 1'b0;
`ifdef UART_TX_BREAK_EN
      tx_break[i] = 1'b0;
`endif
    end

    // Reset state of every instance.
    #12;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tx_serial[%0d]", i), 32'(tx_serial[i]), 32'd1);
      check($sformatf("rst_s_ready[%0d]", i),   32'(s_ready[i]),   32'd1);
      check($sformatf("rst_tx_busy[%0d]", i),   32'(tx_busy[i]),   32'd0);
      check($sformatf("rst_tx_done[%0d]", i),   32'(tx_done[i]),   32'd0);
      check($sformatf("rst_state[%0d]", i),     32'(dbg_state[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Hand-computed frames: 8N1 0xA5, 7E1/7O1 0x41, 8N2 MSB-first 0x80.
    vecs[0] = '{idx: 0, word: 9'h0A5, nbits: 10, exp_bits: 32'h34A};
    vecs[1] = '{idx: 1, word: 9'h041, nbits: 10, exp_bits: 32'h282};
    vecs[2] = '{idx: 2, word: 9'h041, nbits: 10, exp_bits: 32'h382};
    vecs[3] = '{idx: 3, word: 9'h080, nbits: 11, exp_bits: 32'h602};
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].idx, vecs[v].word);
      capture(vecs[v].idx, vecs[v].nbits, bits, done_m, rdy_m, busy_m, bad);
      check($sformatf("vec%0d_bits", v),   bits,   vecs[v].exp_bits);
      check($sformatf("vec%0d_timing", v), 32'(bad), 32'd0);
      check($sformatf("vec%0d_done", v),   done_m, 32'd1 << (vecs[v].nbits - 1));
      check($sformatf("vec%0d_busy", v),   busy_m, (32'd1 << vecs[v].nbits) - 32'd1);
      check($sformatf("vec%0d_idle_after", v), 32'(tx_busy[vecs[v].idx]), 32'd0);
    end

    // Random words on every configuration against the model.
    for (int g = 0; g < NI; g++) begin
      for (int k = 0; k < 3; k++) begin
        w = 9'($urandom_range((1 << cfg_db[g]) - 1, 0));
        model_frame(g, w, n0, f0);
        exp_q.push_back(f0);
        send(g, w);
        capture(g, n0, bits, done_m, rdy_m, busy_m, bad);
        exp_f = exp_q.pop_front();
        check($sformatf("rand%0d_%0d_bits w=%0h", g, k, w), bits, exp_f);
        check($sformatf("rand%0d_%0d_timing", g, k), 32'(bad), 32'd0);
        check($sformatf("rand%0d_%0d_done", g, k), done_m, 32'd1 << (n0 - 1));
      end
    end

    // Back-to-back: 0x0F queued while 0x55 is in its data bits.
    model_frame(0, 9'h055, n0, f0);
    model_frame(0, 9'h00F, n1, f1);
    send(0, 9'h055);
    fork
      capture(0, 20, bits, done_m, rdy_m, busy_m, bad);
      begin
        repeat (4) wait_tick();
        send(0, 9'h00F);
      end
    join
    check("b2b_bits",   bits,   f0 | (f1 << n0));
    check("b2b_timing", 32'(bad), 32'd0);
    check("b2b_done",   done_m, (32'd1 << 9) | (32'd1 << 19));
    check("b2b_ready",  rdy_m,  32'h000FFC0F);
    check("b2b_busy",   busy_m, 32'h000FFFFF);

    // Reset in the middle of 0x3C with 0x99 queued.
    send(0, 9'h03C);
    wait_tick();
    send(0, 9'h099);
    wait_tick();
    wait_tick();
    @(negedge clk);
    check("pre_rst_line",  32'(tx_serial[0]), 32'd0);
    check("pre_rst_ready", 32'(s_ready[0]),   32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_line",  32'(tx_serial[0]), 32'd1);
    check("mid_rst_ready", 32'(s_ready[0]),   32'd1);
    check("mid_rst_busy",  32'(tx_busy[0]),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (320) begin
      @(posedge clk);
      #1;
      if (tx_done[0] !== 1'b0 || tx_serial[0] !== 1'b1 || tx_busy[0] !== 1'b0) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);
    model_frame(0, 9'h012, n0, f0);
    send(0, 9'h012);
    capture(0, n0, bits, done_m, rdy_m, busy_m, bad);
    check("post_rst_bits",   bits, f0);
    check("post_rst_timing", 32'(bad), 32'd0);
    check("post_rst_done",   done_m, 32'd1 << (n0 - 1));

`ifdef UART_TX_BREAK_EN
    // Break for five ticks while 0x33 waits in the holding register.
    model_frame(0, 9'h033, n0, f0);
    @(negedge clk);
    tx_break[0] = 1'b1;
    fork
      capture(0, 16, bits, done_m, rdy_m, busy_m, bad);
      begin
        repeat (2) wait_tick();
        send(0, 9'h033);
        repeat (3) wait_tick();
        @(negedge clk);
        tx_break[0] = 1'b0;
      end
    join
    check("brk_bits",   bits,   (f0 << 6) | 32'h20);
    check("brk_timing", 32'(bad), 32'd0);
    check("brk_busy",   busy_m, 32'h0000FFDF);
    check("brk_done",   done_m, 32'd1 << 15);
`endif

    check("tick_timeouts", 32'(timeouts), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
